// File: rtl/bam_arb_pkg.sv
// Shared types, default BAM geometry and the golden BAM function used by the
// round-robin shared-multiplier arbiter.
package bam_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_H_CUT = 1;
  localparam int DEF_V_CUT = 12;

  // Bit-level sum of every kept partial product a[i]&b[j] at weight i+j.
  function automatic logic [2*DEF_WIDTH-1:0] bam_ref(
    input logic [DEF_WIDTH-1:0] a,
    input logic [DEF_WIDTH-1:0] b
  );
    logic [2*DEF_WIDTH-1:0] p;
    p = '0;
    for (int j = 0; j < DEF_WIDTH; j++) begin
      for (int i = 0; i < DEF_WIDTH; i++) begin
        if (j >= DEF_H_CUT && i + j >= DEF_V_CUT && a[i] && b[j]) begin
          p = p + ((2*DEF_WIDTH)'(1) << (i + j));
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bam_mul_arbiter_if.sv
// Request/response bundle between the accelerator lanes and the shared
// approximate multiplier; the arbiter takes the slave side.
interface bam_mul_arbiter_if
  import bam_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [2*WIDTH-1:0]       resp_prod;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_prod
  );

endinterface

// File: rtl/bam_mul_core.sv
// Purely combinational broken-array multiplier: rows below H_CUT and columns
// below V_CUT are removed before the rows are summed.
module bam_mul_core
  import bam_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int H_CUT = DEF_H_CUT,
  parameter int V_CUT = DEF_V_CUT
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);

  localparam int PW = 2 * WIDTH;

  function automatic logic [PW-1:0] col_mask();
    logic [PW-1:0] m;
    for (int k = 0; k < PW; k++) m[k] = (k >= V_CUT);
    return m;
  endfunction

  localparam logic [PW-1:0] COL_MASK = col_mask();

  // Each row is a shifted copy of a gated by b[j]; the chained accumulators
  // keep each stage in its own scope so the adder chain stays acyclic.
  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    logic [PW-1:0] pp;
    logic [PW-1:0] acc;

    if (j >= H_CUT) begin : g_keep
      assign pp = ((PW'(a) & {PW{b[j]}}) << j) & COL_MASK;
    end else begin : g_drop
      assign pp = '0;
    end

    if (j == 0) begin : g_first
      assign acc = pp;
    end else begin : g_next
      assign acc = g_row[j-1].acc + pp;
    end
  end

  assign prod = g_row[WIDTH-1].acc;

endmodule

// File: rtl/bam_mul_arbiter.sv
// Round-robin arbiter sharing one BAM core among NUM_REQ lanes:
// IDLE grants and registers operands, CALC registers the product, RESP holds it.
module bam_mul_arbiter
  import bam_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int H_CUT   = DEF_H_CUT,
  parameter int V_CUT   = DEF_V_CUT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  bam_mul_arbiter_if.slave bus,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int PW = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [15:0]       op_count_q, op_count_d;
  logic [NUM_REQ-1:0] req_ready_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_idx;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [PW-1:0]     core_prod;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && bus.req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        sel_a = bus.req_a[k*WIDTH +: WIDTH];
        sel_b = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  bam_mul_core #(
    .WIDTH (WIDTH),
    .H_CUT (H_CUT),
    .V_CUT (V_CUT)
  ) u_core (
    .a    (op_a_q),
    .b    (op_b_q),
    .prod (core_prod)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    resp_id_d   = resp_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    prod_d      = prod_q;
    op_count_d  = op_count_q;
    req_ready_d = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready_d = NUM_REQ'(1) << grant_id;
          id_d        = grant_id;
          op_a_d      = sel_a;
          op_b_d      = sel_b;
          state_d     = CALC;
        end
      end
      CALC: begin
        prod_d    = core_prod;
        resp_id_d = id_q;
        state_d   = RESP;
      end
      RESP: begin
        // No new grant is offered until the current result is taken.
        if (bus.resp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(resp_id_q);
          if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      resp_id_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      prod_q     <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      resp_id_q  <= resp_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      prod_q     <= prod_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_prod  = prod_q;
  assign busy           = (state_q != IDLE);
  assign op_count       = op_count_q;

  if (WIDTH == DEF_WIDTH && H_CUT == DEF_H_CUT && V_CUT == DEF_V_CUT) begin : g_ref_chk
    always_ff @(posedge clk) begin
      if (!rst && state_q == CALC) assert (core_prod == bam_ref(op_a_q, op_b_q));
    end
  end

endmodule
